// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the game sequencer: FSM state encodings, the widths
// of the score (4-digit BCD), obstacle gap and tick period fields, and
// saturating-decrement helpers used by the difficulty ramp.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int BCD_W = 16;  // 4 BCD digits
    localparam int GAP_W = 9;   // min_empty in pixels
    localparam int DIV_W = 20;  // tick period in clk cycles

    typedef logic [BCD_W-1:0] bcd_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    // Decrement by step but never below floor; the subtraction is only
    // taken once it is known not to wrap.
    function automatic logic [DIV_W-1:0] sat_dec_div(input logic [DIV_W-1:0] v,
                                                     input logic [DIV_W-1:0] step,
                                                     input logic [DIV_W-1:0] floor);
        if (v >= step && (v - step) >= floor) return v - step;
        else                                  return floor;
    endfunction

    function automatic logic [GAP_W-1:0] sat_dec_gap(input logic [GAP_W-1:0] v,
                                                     input logic [GAP_W-1:0] step,
                                                     input logic [GAP_W-1:0] floor);
        if (v >= step && (v - step) >= floor) return v - step;
        else                                  return floor;
    endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running period counter for the game tick. While enabled it counts
// clk cycles and flags due_o on the last cycle of each period, reloading to
// zero on that same cycle. When disabled the counter is forced to zero, so
// the first enabled cycle always starts a fresh interval.
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   en_i      count enable (running and no collision this cycle)
//   period_i  interval length in clk cycles (>= 1)
//   due_o     high on the final cycle of the current interval
// ---------------------------------------------------------------------------
module tick_divider
    import game_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             due_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d, cnt_inc;

    // Comparing cnt+1 against period avoids a period-1 term that would
    // wrap for a zero period.
    assign cnt_inc = cnt_q + DIV_W'(1);
    assign due_o   = en_i && (cnt_inc == period_i);

    always_comb begin
        cnt_d = cnt_inc;
        if (!en_i || due_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
// Top-level game control: IDLE/START/RUN/OVER FSM, game tick generation via
// tick_divider, difficulty ramp (shorter tick period and obstacle gap each
// time the score's hundreds digit changes) and best-score tracking.
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   start_btn_i  start/restart button (level, synchronised)
//   collide_i    dino/obstacle overlap (level)
//   score_i      current score, 4-digit BCD
//   game_tick_o  one-cycle datapath advance enable
//   obs_rst_o    datapath restart pulse (high in START)
//   over_o       game-over flag
//   min_empty_o  current minimum obstacle gap
//   state_o      FSM state
//   hi_score_o   best score, BCD
// ---------------------------------------------------------------------------
module game_sequencer
    import game_pkg::*;
#(
    parameter logic [DIV_W-1:0] DIV_INIT = 20'd400000,
    parameter logic [DIV_W-1:0] DIV_MIN  = 20'd150000,
    parameter logic [DIV_W-1:0] DIV_STEP = 20'd10000,
    parameter logic [GAP_W-1:0] GAP_INIT = 9'd300,
    parameter logic [GAP_W-1:0] GAP_MIN  = 9'd150,
    parameter logic [GAP_W-1:0] GAP_STEP = 9'd10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_btn_i,
    input  logic             collide_i,
    input  logic [BCD_W-1:0] score_i,
    output logic             game_tick_o,
    output logic             obs_rst_o,
    output logic             over_o,
    output logic [GAP_W-1:0] min_empty_o,
    output logic [1:0]       state_o,
    output logic [BCD_W-1:0] hi_score_o
);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [3:0]       hund_q, hund_d;
    logic             armed_q, armed_d;
    bcd_t             hi_q, hi_d;

    logic run, due, level_up;

    assign run = (state_q == ST_RUN);

    // A collision stops the counter this cycle, which also suppresses the
    // tick and any level-up that would have coincided with it.
    tick_divider u_div (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (run && !collide_i),
        .period_i (period_q),
        .due_o    (due)
    );

    assign level_up = due && (score_i[11:8] != hund_q);

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        gap_d    = gap_q;
        hund_d   = hund_q;
        armed_d  = armed_q;
        hi_d     = hi_q;
        case (state_q)
            ST_IDLE: begin
                if (start_btn_i) state_d = ST_START;
            end
            ST_START: begin
                state_d  = ST_RUN;
                period_d = DIV_INIT;
                gap_d    = GAP_INIT;
                hund_d   = 4'd0;
            end
            ST_RUN: begin
                if (collide_i) begin
                    state_d = ST_OVER;
                    armed_d = 1'b0;
                    if (score_i > hi_q) hi_d = score_i;
                end else if (level_up) begin
                    // The divider reloads on this same cycle, so the new
                    // period governs the next interval.
                    hund_d   = score_i[11:8];
                    period_d = sat_dec_div(period_q, DIV_STEP, DIV_MIN);
                    gap_d    = sat_dec_gap(gap_q, GAP_STEP, GAP_MIN);
                end
            end
            ST_OVER: begin
                // Must see the button released before a restart is accepted.
                if (start_btn_i && armed_q) state_d = ST_START;
                if (!start_btn_i)           armed_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            period_q <= DIV_INIT;
            gap_q    <= GAP_INIT;
            hund_q   <= 4'd0;
            armed_q  <= 1'b0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            gap_q    <= gap_d;
            hund_q   <= hund_d;
            armed_q  <= armed_d;
            hi_q     <= hi_d;
        end
    end

    // START forces a tick so a tick-gated datapath samples obs_rst.
    assign game_tick_o = !rst_i && ((state_q == ST_START) || due);
    assign obs_rst_o   = (state_q == ST_START);
    assign over_o      = (state_q == ST_OVER);
    assign min_empty_o = gap_q;
    assign state_o     = state_q;
    assign hi_score_o  = hi_q;

endmodule

// File: tb/tb_game_sequencer.sv
module tb_game_sequencer;

    localparam int DI = 8, DM = 4, DS = 2, GI = 20, GM = 14, GS = 3;

    logic        clk = 1'b0;
    logic        rst, start_btn, collide;
    logic [15:0] score;
    logic        game_tick, obs_rst, over;
    logic [8:0]  min_empty;
    logic [1:0]  state;
    logic [15:0] hi_score;

    always #5 clk = ~clk;

    game_sequencer #(
        .DIV_INIT(20'd8), .DIV_MIN(20'd4), .DIV_STEP(20'd2),
        .GAP_INIT(9'd20), .GAP_MIN(9'd14), .GAP_STEP(9'd3)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_btn_i(start_btn), .collide_i(collide),
        .score_i(score), .game_tick_o(game_tick), .obs_rst_o(obs_rst),
        .over_o(over), .min_empty_o(min_empty), .state_o(state),
        .hi_score_o(hi_score)
    );

    int total = 0, bad = 0;
    int cyc = 0;

    // Reference model: game phase 0..3, tick scheduled as an absolute cycle.
    int m_phase, m_period, m_gap, m_hund, m_next, m_hi;
    bit m_armed;

    int last_tick = 0, last_gap = 0, ntick = 0;
    int sval = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int floor_dec(input int v, input int st, input int fl);
        return (v - st < fl) ? fl : v - st;
    endfunction

    // Drive one cycle of inputs, compare against the model, advance both.
    task automatic step(input logic r, input logic b, input logic c, input logic [15:0] s);
        logic e_tick;
        rst = r; start_btn = b; collide = c; score = s;
        #1;
        e_tick = !r && ((m_phase == 1) || (m_phase == 2 && !c && cyc == m_next));
        chk("state",     32'(state),     32'(m_phase));
        chk("over",      32'(over),      32'(m_phase == 3));
        chk("obs_rst",   32'(obs_rst),   32'(m_phase == 1));
        chk("tick",      32'(game_tick), 32'(e_tick));
        chk("min_empty", 32'(min_empty), 32'(m_gap));
        chk("hi_score",  32'(hi_score),  32'(m_hi));
        if (game_tick === 1'b1) begin
            last_gap  = cyc - last_tick;
            last_tick = cyc;
            ntick++;
        end
        if (r) begin
            m_phase = 0; m_period = DI; m_gap = GI; m_hund = 0; m_armed = 0; m_hi = 0;
        end else begin
            case (m_phase)
                0: if (b) m_phase = 1;
                1: begin
                    m_phase = 2; m_period = DI; m_gap = GI; m_hund = 0;
                    m_next = cyc + m_period;
                end
                2: begin
                    if (c) begin
                        m_phase = 3; m_armed = 0;
                        if (int'(s) > m_hi) m_hi = int'(s);
                    end else if (cyc == m_next) begin
                        if (int'(s[11:8]) != m_hund) begin
                            m_hund   = int'(s[11:8]);
                            m_period = floor_dec(m_period, DS, DM);
                            m_gap    = floor_dec(m_gap, GS, GM);
                        end
                        m_next = cyc + m_period;
                    end
                end
                default: begin
                    if (b && m_armed) m_phase = 1;
                    if (!b) m_armed = 1;
                end
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n, input logic [15:0] s);
        int target, guard;
        target = ntick + n;
        guard  = 0;
        while (ntick < target && guard < 200) begin
            step(1'b0, 1'b0, 1'b0, s);
            guard++;
        end
        chk("ticks_seen", 32'(ntick), 32'(target));
    endtask

    task automatic restart(input logic [15:0] s);
        step(1'b0, 1'b0, 1'b0, s);
        step(1'b0, 1'b1, 1'b0, s);
        chk("restart_start", 32'(state), 32'd1);
        step(1'b0, 1'b0, 1'b0, s);
        chk("restart_run", 32'(state), 32'd2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst = 1'b1; start_btn = 1'b0; collide = 1'b0; score = 16'h0;
        m_phase = 0; m_period = DI; m_gap = GI; m_hund = 0; m_armed = 0; m_hi = 0; m_next = 0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 16'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_gap", 32'(min_empty), 32'd20);
        chk("rst_hi", 32'(hi_score), 32'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 16'h0);

        // Game 1: start pulse, tick every 8
        step(1'b0, 1'b1, 1'b0, 16'h0045);
        chk("g1_start", 32'(state), 32'd1);
        chk("g1_obs_rst", 32'(obs_rst), 32'd1);
        step(1'b0, 1'b0, 1'b0, 16'h0045);
        chk("g1_run", 32'(state), 32'd2);
        chk("g1_obs_low", 32'(obs_rst), 32'd0);
        run_ticks(2, 16'h0045);
        chk("g1_interval", 32'(last_gap), 32'd8);
        step(1'b0, 1'b0, 1'b1, 16'h0045);
        chk("g1_hi", 32'(hi_score), 32'h0045);

        // Game 2: collide at 0x0123 with the button held from then on
        restart(16'h0123);
        run_ticks(1, 16'h0123);
        step(1'b0, 1'b1, 1'b1, 16'h0123);
        chk("g2_over", 32'(over), 32'd1);
        chk("g2_hi", 32'(hi_score), 32'h0123);
        repeat (5) step(1'b0, 1'b1, 1'b0, 16'h0123);
        chk("g2_held", 32'(state), 32'd3);
        restart(16'h0099);
        chk("g2_gap_reload", 32'(min_empty), 32'd20);
        chk("g2_hi_kept", 32'(hi_score), 32'h0123);

        // Game 3: difficulty ramp
        run_ticks(2, 16'h0099);
        chk("ramp_p8", 32'(last_gap), 32'd8);
        run_ticks(1, 16'h0100);
        chk("ramp_gap17", 32'(min_empty), 32'd17);
        run_ticks(1, 16'h0100);
        chk("ramp_p6", 32'(last_gap), 32'd6);
        run_ticks(1, 16'h0200);
        chk("ramp_gap14", 32'(min_empty), 32'd14);
        run_ticks(1, 16'h0200);
        chk("ramp_p4", 32'(last_gap), 32'd4);
        run_ticks(1, 16'h0300);
        run_ticks(1, 16'h0300);
        chk("ramp_p4_floor", 32'(last_gap), 32'd4);
        chk("ramp_gap_floor", 32'(min_empty), 32'd14);
        step(1'b0, 1'b0, 1'b1, 16'h0300);
        chk("g3_hi", 32'(hi_score), 32'h0300);

        // Game 4: collide on the level-up tick cycle
        restart(16'h0300);
        guard = 0;
        while (cyc != m_next && guard < 50) begin
            step(1'b0, 1'b0, 1'b0, 16'h0300);
            guard++;
        end
        chk("g4_reach_tick", 32'(cyc), 32'(m_next));
        step(1'b0, 1'b0, 1'b1, 16'h0300);
        chk("g4_over", 32'(state), 32'd3);
        chk("g4_gap_kept", 32'(min_empty), 32'd20);

        // Game 5: reset mid-run
        restart(16'h0123);
        run_ticks(1, 16'h0123);
        step(1'b1, 1'b0, 1'b0, 16'h0123);
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_hi", 32'(hi_score), 32'd0);
        chk("mid_rst_gap", 32'(min_empty), 32'd20);
        chk("mid_rst_over", 32'(over), 32'd0);
        chk("mid_rst_tick", 32'(game_tick), 32'd0);

        // Random play against the model
        sval = 0;
        repeat (3000) begin
            logic r, b, c;
            r = ($urandom_range(0, 499) == 0);
            b = ($urandom_range(0, 7) == 0);
            c = ($urandom_range(0, 39) == 0);
            sval = (sval + int'($urandom_range(0, 2))) % 10000;
            step(r, b, c, to_bcd(sval));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
